// File: rtl/dmem_bridge.sv
`default_nettype none
// dmem_bridge: multi-cycle load/store bridge between the hart dmem port and a ready/valid memory.
// Optional abort counter enabled by DMEM_BRIDGE_TIMEOUT_EN. Revision: 1.0
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    input  logic [31:0] i_req_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic        o_fault,
    output logic [31:0] o_rdata,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_ready,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_rdata
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [1:0]  size_q;
    logic        uns_q, store_q;
    logic [3:0]  mask_q;

    logic        req_any, illegal, abort, timeout_hit, fault_q;
    logic [3:0]  mask_new;
    logic [31:0] wdata_new, rshift, rext;

    assign req_any   = i_req_ren | i_req_wen;
    assign wdata_new = i_req_wdata << {i_req_addr[1:0], 3'b000};
    assign rshift    = i_mem_rdata >> {addr_q[1:0], 3'b000};
    assign o_rdata   = rdata_q;

    always_comb begin
        illegal  = 1'b0;
        mask_new = 4'b1111;
        if (i_req_ren && i_req_wen)                   illegal = 1'b1;
        if (i_req_size == 2'b11)                      illegal = 1'b1;
        if (i_req_size == 2'b01 && i_req_addr[0])     illegal = 1'b1;
        if (i_req_size == 2'b10 && |i_req_addr[1:0])  illegal = 1'b1;
        case (i_req_size)
            2'b00:   mask_new = 4'b0001 << i_req_addr[1:0];
            2'b01:   mask_new = 4'b0011 << i_req_addr[1:0];
            default: mask_new = 4'b1111;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   rext = uns_q ? {24'b0, rshift[7:0]}  : {{24{rshift[7]}}, rshift[7:0]};
            2'b01:   rext = uns_q ? {16'b0, rshift[15:0]} : {{16{rshift[15]}}, rshift[15:0]};
            default: rext = rshift;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        abort       = 1'b0;
        o_stall     = 1'b0;
        o_done      = 1'b0;
        o_fault     = 1'b0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        o_mem_addr  = 32'b0;
        o_mem_mask  = 4'b0;
        o_mem_wdata = 32'b0;
        case (state)
            ST_IDLE: begin
                // Gated by reset so every output reads zero while reset is held.
                if (req_any && !i_rst) begin
                    if (illegal) begin
                        o_fault = 1'b1;
                    end else begin
                        o_stall   = 1'b1;
                        state_nxt = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                o_stall     = 1'b1;
                o_mem_addr  = {addr_q[31:2], 2'b00};
                o_mem_mask  = mask_q;
                o_mem_wdata = wdata_q;
                o_mem_ren   = !store_q;
                o_mem_wen   = store_q;
                if (i_mem_ready) begin
                    state_nxt = store_q ? ST_DONE : ST_WAIT;
                end
                if (timeout_hit && !(i_mem_ready && store_q)) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end
            end
            ST_WAIT: begin
                o_stall = 1'b1;
                if (i_mem_valid) begin
                    state_nxt = ST_DONE;
                end else if (timeout_hit) begin
                    state_nxt = ST_DONE;
                    abort     = 1'b1;
                end
            end
            default: begin
                o_done    = 1'b1;
                o_fault   = fault_q;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            addr_q  <= 32'b0;
            size_q  <= 2'b0;
            uns_q   <= 1'b0;
            store_q <= 1'b0;
            wdata_q <= 32'b0;
            mask_q  <= 4'b0;
            rdata_q <= 32'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && state_nxt == ST_REQ) begin
                addr_q  <= i_req_addr;
                size_q  <= i_req_size;
                uns_q   <= i_req_unsigned;
                store_q <= i_req_wen;
                wdata_q <= wdata_new;
                mask_q  <= mask_new;
            end
            if (abort) begin
                rdata_q <= 32'b0;
            end else if (state == ST_REQ && i_mem_ready && store_q) begin
                rdata_q <= 32'b0;
            end else if (state == ST_WAIT && i_mem_valid) begin
                rdata_q <= rext;
            end
        end
    end

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    logic [7:0] to_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            to_cnt  <= 8'b0;
            fault_q <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                to_cnt <= 8'b0;
            end else if (state == ST_REQ || state == ST_WAIT) begin
                to_cnt <= to_cnt + 8'd1;
            end
            if (state_nxt == ST_DONE) begin
                fault_q <= abort;
            end
        end
    end

    assign timeout_hit = (to_cnt == 8'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign fault_q            = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_bridge.sv
`default_nettype none
// tb_dmem_bridge: directed vectors with hand-computed expectations for dmem_bridge.
`timescale 1ns/1ps
module tb_dmem_bridge;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [31:0] i_req_addr = '0;
    logic        i_req_ren = 1'b0;
    logic        i_req_wen = 1'b0;
    logic [1:0]  i_req_size = '0;
    logic        i_req_unsigned = 1'b0;
    logic [31:0] i_req_wdata = '0;
    logic        i_mem_ready = 1'b0;
    logic        i_mem_valid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_stall, o_done, o_fault, o_mem_ren, o_mem_wen;
    logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_mask;

    dmem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req_addr(i_req_addr), .i_req_ren(i_req_ren), .i_req_wen(i_req_wen),
        .i_req_size(i_req_size), .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
        .o_stall(o_stall), .o_done(o_done), .o_fault(o_fault), .o_rdata(o_rdata),
        .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren), .o_mem_wen(o_mem_wen),
        .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
        .i_mem_ready(i_mem_ready), .i_mem_valid(i_mem_valid), .i_mem_rdata(i_mem_rdata)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    logic [31:0] g_addr, g_wdata, g_rdata;
    logic [3:0]  g_mask;
    logic        g_fault, g_done, g_both, g_req_stall;
    int          g_stall;

    // Acts as the memory: ready after rdy_dly REQ cycles, valid after vld_dly WAIT cycles.
    task automatic access(input logic ren, input logic wen, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int rdy_dly, input int vld_dly);
        int  rk = 0;
        int  wk = 0;
        bit  seen = 0;
        g_stall = 0; g_done = 0; g_both = 0; g_fault = 0;
        g_addr = '0; g_wdata = '0; g_mask = '0; g_rdata = '0;
        @(negedge i_clk);
        i_req_addr = addr; i_req_ren = ren; i_req_wen = wen; i_req_size = size;
        i_req_unsigned = uns; i_req_wdata = wdata; i_mem_rdata = rdata;
        #1 g_req_stall = o_stall;
        @(negedge i_clk);
        i_req_ren = 1'b0; i_req_wen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (o_mem_ren && o_mem_wen) g_both = 1'b1;
            if (o_done) begin
                g_done = 1'b1; g_fault = o_fault; g_rdata = o_rdata;
                break;
            end
            if (o_stall) g_stall++;
            if (o_mem_ren || o_mem_wen) begin
                if (!seen) begin
                    g_addr = o_mem_addr; g_mask = o_mem_mask; g_wdata = o_mem_wdata; seen = 1;
                end
                i_mem_ready = (rk == rdy_dly); rk++;
                i_mem_valid = 1'b0;
            end else if (o_stall) begin
                i_mem_ready = 1'b0;
                i_mem_valid = (wk == vld_dly); wk++;
            end else begin
                i_mem_ready = 1'b0; i_mem_valid = 1'b0;
            end
            @(negedge i_clk);
        end
        i_mem_ready = 1'b0; i_mem_valid = 1'b0;
        check("access_done", {31'b0, g_done}, 32'd1);
        check("no_ren_wen_overlap", {31'b0, g_both}, 32'd0);
    endtask

    logic [31:0] ill_addr [4] = '{32'h0000_0102, 32'h0000_0000, 32'h0000_0010, 32'h0000_1001};
    logic [1:0]  ill_size [4] = '{2'b10, 2'b10, 2'b11, 2'b01};
    logic        ill_ren  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic        ill_wen  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        @(negedge i_clk);
        #1;
        check("rst_ctrl", {27'b0, o_stall, o_done, o_fault, o_mem_ren, o_mem_wen}, 32'd0);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_mem_addr", o_mem_addr, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;

        // sb 0x2003, ready on third REQ cycle
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_2003, 32'h0000_00AB, 32'h0, 2, 0);
        check("sb_req_stall", {31'b0, g_req_stall}, 32'd1);
        check("sb_addr", g_addr, 32'h0000_2000);
        check("sb_mask", {28'b0, g_mask}, 32'h8);
        check("sb_wdata", g_wdata, 32'hAB00_0000);
        check("sb_stall", g_stall, 32'd3);
        check("sb_fault", {31'b0, g_fault}, 32'd0);
        check("sb_rdata", g_rdata, 32'd0);
        @(negedge i_clk); #1;
        check("sb_done_pulse", {31'b0, o_done}, 32'd0);

        // lh 0x1002, valid on fourth WAIT cycle
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_1002, 32'h0, 32'h8765_1234, 0, 3);
        check("lh_mask", {28'b0, g_mask}, 32'hC);
        check("lh_addr", g_addr, 32'h0000_1000);
        check("lh_stall", g_stall, 32'd5);
        check("lh_rdata", g_rdata, 32'hFFFF_8765);
        @(negedge i_clk); #1;
        check("lh_rdata_hold", o_rdata, 32'hFFFF_8765);

        access(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_1002, 32'h0, 32'h8765_1234, 0, 3);
        check("lhu_rdata", g_rdata, 32'h0000_8765);

        // lw 0x100 at minimum latency
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, 0);
        check("lw_stall", g_stall, 32'd2);
        check("lw_mask", {28'b0, g_mask}, 32'hF);
        check("lw_rdata", g_rdata, 32'hDEAD_BEEF);

        // stray valid in IDLE
        @(negedge i_clk);
        i_mem_valid = 1'b1; i_mem_rdata = 32'h1111_1111;
        @(negedge i_clk);
        i_mem_valid = 1'b0;
        #1;
        check("idle_valid_ignored", o_rdata, 32'hDEAD_BEEF);

        // illegal requests: fault same cycle, no memory activity
        for (int k = 0; k < 4; k++) begin
            logic act;
            act = 1'b0;
            @(negedge i_clk);
            i_req_addr = ill_addr[k]; i_req_size = ill_size[k];
            i_req_ren = ill_ren[k]; i_req_wen = ill_wen[k];
            #1;
            check($sformatf("illegal%0d_fault_stall", k), {30'b0, o_fault, o_stall}, 32'd2);
            act = act | o_mem_ren | o_mem_wen;
            @(negedge i_clk);
            i_req_ren = 1'b0; i_req_wen = 1'b0;
            #1;
            act = act | o_mem_ren | o_mem_wen | o_stall;
            check($sformatf("illegal%0d_no_access", k), {31'b0, act}, 32'd0);
        end

        access(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0002, 32'h0000_BEEF, 32'h0, 0, 0);
        check("sh_mask", {28'b0, g_mask}, 32'hC);
        check("sh_wdata", g_wdata, 32'hBEEF_0000);
        check("sh_stall", g_stall, 32'd1);

        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 32'h8000_0000, 1, 1);
        check("lb_sign_rdata", g_rdata, 32'hFFFF_FF80);

        // reset while in WAIT
        @(negedge i_clk);
        i_req_addr = 32'h0000_0200; i_req_size = 2'b10; i_req_ren = 1'b1; i_req_wen = 1'b0;
        @(negedge i_clk);
        i_req_ren = 1'b0; i_mem_ready = 1'b1;
        @(negedge i_clk);
        i_mem_ready = 1'b0;
        #1;
        check("wait_before_rst", {30'b0, o_stall, o_mem_ren}, 32'd2);
        i_rst = 1'b1;
        #1;
        check("rst_mid_ctrl", {23'b0, o_stall, o_done, o_fault, o_mem_ren, o_mem_wen, o_mem_mask}, 32'd0);
        check("rst_mid_rdata", o_rdata, 32'd0);
        check("rst_mid_mem_addr", o_mem_addr, 32'd0);
        check("rst_mid_mem_wdata", o_mem_wdata, 32'd0);
        i_mem_valid = 1'b1; i_mem_rdata = 32'h5555_5555;
        @(negedge i_clk);
        i_rst = 1'b0; i_mem_valid = 1'b0;
        @(negedge i_clk); #1;
        check("post_rst_idle", {30'b0, o_stall, o_done}, 32'd0);
        check("post_rst_rdata", o_rdata, 32'd0);

        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0005, 32'h0, 32'h0000_7F00, 0, 0);
        check("lb_after_rst_addr", g_addr, 32'h0000_0004);
        check("lb_after_rst_mask", {28'b0, g_mask}, 32'h2);
        check("lb_after_rst_rdata", g_rdata, 32'h0000_007F);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        access(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0, 32'hCAFE_F00D, 0, 1000);
        check("to_fault", {31'b0, g_fault}, 32'd1);
        check("to_rdata", g_rdata, 32'd0);
        check("to_stall", g_stall, 32'd4);
        @(negedge i_clk);
        i_mem_valid = 1'b1;
        @(negedge i_clk);
        i_mem_valid = 1'b0;
        #1;
        check("to_late_valid", o_rdata, 32'd0);
        check("to_late_ctrl", {29'b0, o_stall, o_done, o_fault}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
